// File: rtl/on_line_adder_core_pkg.sv
// Shared digit types and constants for the radix-2 signed-digit online arithmetic blocks.
package online_arith_pkg;

    // Signed digit {pos, neg}; value is pos - neg, and 2'b11 is also zero.
    typedef struct packed {
        logic pos;
        logic neg;
    } digit_t;

    localparam int unsigned ONLINE_DELAY = 2;

    localparam digit_t DIGIT_ZERO      = '{pos: 1'b0, neg: 1'b0};
    localparam digit_t DIGIT_PLUS_ONE  = '{pos: 1'b1, neg: 1'b0};
    localparam digit_t DIGIT_MINUS_ONE = '{pos: 1'b0, neg: 1'b1};

    // Inverting both bits negates a digit; callers use this to subtract.
    function automatic digit_t digit_negate(input digit_t d);
        return ~d;
    endfunction

endpackage

// File: rtl/on_line_adder_core_if.sv
// Digit stream bundle for the online adder; out_vld exists only with ONLINE_ADDER_VLD_EN.
interface on_line_adder_core_if;
    import online_arith_pkg::*;

    logic   en;
    digit_t x;
    digit_t y;
    digit_t res;
`ifdef ONLINE_ADDER_VLD_EN
    logic   out_vld;

    modport master (output en, output x, output y, input res, input out_vld);
    modport slave  (input en, input x, input y, output res, output out_vld);
`else
    modport master (output en, output x, output y, input res);
    modport slave  (input en, input x, input y, output res);
`endif
endinterface

// File: rtl/on_line_adder_core_fa.sv
// One-bit full adder used for both borrow-save stages of the online adder.
module online_fa (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);
    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/on_line_adder_core.sv
// Radix-2 MSB-first borrow-save online adder, online delay 2.
// Define ONLINE_ADDER_VLD_EN to add out_vld, raised once the pipeline holds real digits.
module on_line_adder_core
    import online_arith_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    on_line_adder_core_if.slave  bus
);
    logic   h, g, t, s;
    logic   x_neg_n, ym_r_n;
    logic   g_r, ym_r, s_r;
    digit_t res_r;

    assign x_neg_n = ~bus.x.neg;
    assign ym_r_n  = ~ym_r;

    online_fa u_stage1 (
        .a    (bus.x.pos),
        .b    (x_neg_n),
        .cin  (bus.y.pos),
        .sum  (g),
        .cout (h)
    );

    online_fa u_stage2 (
        .a    (g_r),
        .b    (ym_r_n),
        .cin  (h),
        .sum  (s),
        .cout (t)
    );

    // Reset values encode an empty stream (zero residual), so no warm-up is needed.
    always_ff @(posedge clk) begin
        if (rst) begin
            g_r   <= 1'b1;
            ym_r  <= 1'b0;
            s_r   <= 1'b0;
            res_r <= DIGIT_ZERO;
        end else if (bus.en) begin
            g_r   <= g;
            ym_r  <= bus.y.neg;
            s_r   <= s;
            res_r <= '{pos: t, neg: ~s_r};
        end
    end

    assign bus.res = res_r;

`ifdef ONLINE_ADDER_VLD_EN
    logic [1:0] vld_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_cnt <= '0;
        end else if (bus.en && (vld_cnt != '1)) begin
            vld_cnt <= vld_cnt + 2'd1;
        end
    end

    assign bus.out_vld = (vld_cnt >= 2'(ONLINE_DELAY));
`endif

endmodule

// File: tb/tb_on_line_adder_core.sv
// Self-checking bench: residual model of the digit stream plus directed literal vectors.
module tb_on_line_adder_core;
    import online_arith_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    on_line_adder_core_if bus ();

    on_line_adder_core dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic int dval(input logic [1:0] d);
        return int'(d[1]) - int'(d[0]);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Residual model: d = 2^k * (input prefix sum - output prefix sum), output j weighs 2^(2-j).
    // A delay-2 adder keeps |d| <= 2, and d must be exactly 0 after two zero pairs.
    initial begin : cmp
        longint     d;
        int         zrun;
        int         nen;
        logic [1:0] held;
        logic       c_rst, c_en;
        logic [1:0] cx, cy;
        d    = 0;
        zrun = 0;
        nen  = 0;
        held = 2'b00;
        forever begin
            @(posedge clk);
            c_rst = rst;
            c_en  = bus.en;
            cx    = bus.x;
            cy    = bus.y;
            #1;
            if (c_rst === 1'b1) begin
                d    = 0;
                zrun = 0;
                nen  = 0;
                chk("reset_res", int'(bus.res), 0);
            end else if (c_en === 1'b1) begin
                nen++;
                d = 2 * d + longint'(dval(cx) + dval(cy) - 4 * dval(bus.res));
                chk("residual_bound", int'(d >= -2 && d <= 2), 1);
                if (d < -2 || d > 2) d = 0;
                if (dval(cx) == 0 && cy == 2'b00) zrun++;
                else zrun = 0;
                if (zrun >= 2) chk("exact_sum", int'(d), 0);
            end else begin
                chk("hold_res", int'(bus.res), int'(held));
            end
`ifdef ONLINE_ADDER_VLD_EN
            chk("out_vld", int'(bus.out_vld), int'(nen >= 2));
`endif
            held = bus.res;
        end
    end

    task automatic step(input logic r, input logic e, input logic [1:0] xi, input logic [1:0] yi);
        @(negedge clk);
        rst    = r;
        bus.en = e;
        bus.x  = xi;
        bus.y  = yi;
        @(posedge clk);
        #2;
    endtask

    task automatic dig(input string name, input logic r, input logic e,
                       input logic [1:0] xi, input logic [1:0] yi, input logic [1:0] exp);
        step(r, e, xi, yi);
        chk(name, int'(bus.res), int'(exp));
    endtask

    initial begin
        rst    = 1'b1;
        bus.en = 1'b0;
        bus.x  = 2'b00;
        bus.y  = 2'b00;
        dig("reset", 1'b1, 1'b0, 2'b00, 2'b00, 2'b00);

        // 0.5 + 0.5 = 1.0
        dig("add_d1", 1'b0, 1'b1, 2'b10, 2'b10, 2'b11);
        dig("add_d2", 1'b0, 1'b1, 2'b00, 2'b00, 2'b10);
        dig("add_d3", 1'b0, 1'b1, 2'b00, 2'b00, 2'b11);

        // 0.5 - 0.5 = 0
        dig("sub_d1", 1'b0, 1'b1, 2'b10, 2'b01, 2'b11);
        dig("sub_d2", 1'b0, 1'b1, 2'b00, 2'b00, 2'b00);
        dig("sub_d3", 1'b0, 1'b1, 2'b00, 2'b00, 2'b11);

        // -0.5 + -0.5 = -1.0
        dig("neg_d1", 1'b0, 1'b1, 2'b01, 2'b01, 2'b11);
        dig("neg_d2", 1'b0, 1'b1, 2'b00, 2'b00, 2'b01);
        dig("neg_d3", 1'b0, 1'b1, 2'b00, 2'b00, 2'b11);

        // x digit 11 taken as zero: 0 + 0.5 = 0.5
        dig("z11_d1", 1'b0, 1'b1, 2'b11, 2'b10, 2'b11);
        dig("z11_d2", 1'b0, 1'b1, 2'b00, 2'b00, 2'b00);
        dig("z11_d3", 1'b0, 1'b1, 2'b00, 2'b00, 2'b10);
        dig("z11_d4", 1'b0, 1'b1, 2'b00, 2'b00, 2'b11);

        // Stall with garbage inputs after the first digit
        dig("stall_d1", 1'b0, 1'b1, 2'b10, 2'b10, 2'b11);
        dig("stall_h1", 1'b0, 1'b0, 2'b01, 2'b01, 2'b11);
        dig("stall_h2", 1'b0, 1'b0, 2'b10, 2'b11, 2'b11);
        dig("stall_h3", 1'b0, 1'b0, 2'b01, 2'b10, 2'b11);
        dig("stall_d2", 1'b0, 1'b1, 2'b00, 2'b00, 2'b10);
        dig("stall_d3", 1'b0, 1'b1, 2'b00, 2'b00, 2'b11);

        // Reset mid-stream (with en high) then a fresh run
        dig("rst_d1", 1'b0, 1'b1, 2'b10, 2'b10, 2'b11);
        dig("rst_mid", 1'b1, 1'b1, 2'b10, 2'b10, 2'b00);
`ifdef ONLINE_ADDER_VLD_EN
        chk("vld_after_rst", int'(bus.out_vld), 0);
`endif
        dig("rst_r1", 1'b0, 1'b1, 2'b10, 2'b10, 2'b11);
`ifdef ONLINE_ADDER_VLD_EN
        chk("vld_after_1", int'(bus.out_vld), 0);
`endif
        dig("rst_r2", 1'b0, 1'b1, 2'b00, 2'b00, 2'b10);
`ifdef ONLINE_ADDER_VLD_EN
        chk("vld_after_2", int'(bus.out_vld), 1);
`endif
        dig("rst_r3", 1'b0, 1'b1, 2'b00, 2'b00, 2'b11);

        // Random digit stream with stalls, closed by two zero pairs
        for (int i = 0; i < 60; i++) begin
            step(1'b0, ($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
        end
        step(1'b0, 1'b1, 2'b00, 2'b00);
        step(1'b0, 1'b1, 2'b00, 2'b00);
        step(1'b0, 1'b0, 2'b00, 2'b00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
